// File: rtl/accel_mem_arbiter.sv
// Round-robin arbiter sharing one downstream data-memory port between the CPU
// data port and the accelerator load/store port, one transaction at a time.
module accel_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpu_mem_read,
   input  logic                cpu_mem_write,
   input  logic [ADDR_W-1:0]   cpu_mem_address,
   input  logic [DATA_W-1:0]   cpu_mem_wdata,
   input  logic [DATA_W/8-1:0] cpu_mem_wmask,
   output logic                cpu_mem_resp,
   output logic [DATA_W-1:0]   cpu_mem_rdata,
   input  logic                acc_mem_read,
   input  logic                acc_mem_write,
   input  logic [ADDR_W-1:0]   acc_address,
   input  logic [DATA_W-1:0]   acc_st_data,
   output logic                acc_mem_resp,
   output logic [DATA_W-1:0]   acc_data,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                acc_clear,
   output logic [1:0]          busy_owner,
   output logic [CNT_W-1:0]    acc_xfer_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      CPU_BUSY = 2'b01,
      ACC_BUSY = 2'b10
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             last_owner;
   logic             last_owner_next;
   logic             cpu_req;
   logic             acc_req;
   logic [CNT_W-1:0] xfer_count;

   assign cpu_req        = cpu_mem_read | cpu_mem_write;
   assign acc_req        = acc_mem_read | acc_mem_write;
   assign cpu_mem_rdata  = mem_rdata;
   assign acc_data       = mem_rdata;
   assign busy_owner     = state;
   assign acc_xfer_count = xfer_count;

   // last_owner: 1 means ACC was served last, so the CPU wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
      end else begin
         state      <= state_next;
         last_owner <= last_owner_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || acc_clear) begin
         xfer_count <= '0;
      end else if (state == ACC_BUSY && mem_resp) begin
         xfer_count <= xfer_count + CNT_W'(1);
      end
   end

   // Request muxing is combinational from the owner; only the grant is registered.
   always_comb begin
      state_next      = state;
      last_owner_next = last_owner;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = '0;
      mem_wdata       = '0;
      mem_wmask       = '0;
      cpu_mem_resp    = 1'b0;
      acc_mem_resp    = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req && acc_req) begin
               state_next = last_owner ? CPU_BUSY : ACC_BUSY;
            end else if (cpu_req) begin
               state_next = CPU_BUSY;
            end else if (acc_req) begin
               state_next = ACC_BUSY;
            end
         end
         CPU_BUSY: begin
            mem_read    = cpu_mem_read;
            mem_write   = cpu_mem_write;
            mem_address = cpu_mem_address;
            mem_wdata   = cpu_mem_wdata;
            mem_wmask   = cpu_mem_wmask;
            if (mem_resp) begin
               cpu_mem_resp    = 1'b1;
               state_next      = IDLE;
               last_owner_next = 1'b0;
            end
         end
         ACC_BUSY: begin
            mem_read    = acc_mem_read;
            mem_write   = acc_mem_write;
            mem_address = acc_address;
            mem_wdata   = acc_st_data;
            mem_wmask   = '1;
            if (mem_resp) begin
               acc_mem_resp    = 1'b1;
               state_next      = IDLE;
               last_owner_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Directed self-checking bench for accel_mem_arbiter: inputs change on the
// falling edge and outputs are sampled 1ns later.
module tb_accel_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_mem_read, cpu_mem_write;
   logic [31:0] cpu_mem_address, cpu_mem_wdata;
   logic [3:0]  cpu_mem_wmask;
   logic        cpu_mem_resp;
   logic [31:0] cpu_mem_rdata;
   logic        acc_mem_read, acc_mem_write;
   logic [31:0] acc_address, acc_st_data;
   logic        acc_mem_resp;
   logic [31:0] acc_data;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp;
   logic [31:0] mem_rdata;
   logic        acc_clear;
   logic [1:0]  busy_owner;
   logic [31:0] acc_xfer_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   accel_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_mem_address(cpu_mem_address), .cpu_mem_wdata(cpu_mem_wdata),
      .cpu_mem_wmask(cpu_mem_wmask), .cpu_mem_resp(cpu_mem_resp),
      .cpu_mem_rdata(cpu_mem_rdata),
      .acc_mem_read(acc_mem_read), .acc_mem_write(acc_mem_write),
      .acc_address(acc_address), .acc_st_data(acc_st_data),
      .acc_mem_resp(acc_mem_resp), .acc_data(acc_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp(mem_resp),
      .mem_rdata(mem_rdata), .acc_clear(acc_clear),
      .busy_owner(busy_owner), .acc_xfer_count(acc_xfer_count)
   );

   // Protocol rules the requesters must obey.
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(cpu_mem_read && cpu_mem_write)) else $error("[TB] CPU read and write asserted together");
         assert (!(acc_mem_read && acc_mem_write)) else $error("[TB] ACC read and write asserted together");
         if (busy_owner == 2'b01) assert (cpu_mem_read || cpu_mem_write) else $error("[TB] CPU dropped request before mem_resp");
         if (busy_owner == 2'b10) assert (acc_mem_read || acc_mem_write) else $error("[TB] ACC dropped request before mem_resp");
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      cpu_mem_read = 0; cpu_mem_write = 0; cpu_mem_address = 0; cpu_mem_wdata = 0; cpu_mem_wmask = 0;
      acc_mem_read = 0; acc_mem_write = 0; acc_address = 0; acc_st_data = 0;
      mem_resp = 0; mem_rdata = 0; acc_clear = 0;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic acc_txn(input logic [31:0] addr, input logic [31:0] rd, input logic clr);
      int n;
      acc_mem_read = 1'b1;
      acc_address  = addr;
      n = 0;
      tick();
      while (busy_owner !== 2'b10 && n < 4) begin
         tick();
         n++;
      end
      checks++;
      if (busy_owner !== 2'b10) begin
         failures++;
         $display("[TB] FAIL acc_txn_grant got=%b exp=10", busy_owner);
      end
      mem_resp  = 1'b1;
      mem_rdata = rd;
      acc_clear = clr;
      tick();
      mem_resp     = 1'b0;
      acc_mem_read = 1'b0;
      acc_clear    = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (busy_owner !== 2'b00) begin failures++; $display("[TB] FAIL reset_owner got=%b exp=00", busy_owner); end
      checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("[TB] FAIL reset_rw got=%b exp=00", {mem_read, mem_write}); end
      checks++; if (mem_address !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
         failures++; $display("[TB] FAIL reset_bus got=%h/%h/%h exp=0/0/0", mem_address, mem_wdata, mem_wmask); end
      checks++; if ({cpu_mem_resp, acc_mem_resp} !== 2'b00) begin failures++; $display("[TB] FAIL reset_resp got=%b exp=00", {cpu_mem_resp, acc_mem_resp}); end
      checks++; if (acc_xfer_count !== 32'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", acc_xfer_count); end
   endtask

   task automatic test_acc_read();
      do_reset();
      acc_mem_read = 1'b1; acc_address = 32'h1000;
      #1;
      checks++; if (mem_read !== 1'b0) begin failures++; $display("[TB] FAIL accrd_c0_read got=%b exp=0", mem_read); end
      tick(); #1;
      checks++; if (mem_read !== 1'b1 || mem_address !== 32'h1000) begin
         failures++; $display("[TB] FAIL accrd_c1_bus got=%b/%h exp=1/00001000", mem_read, mem_address); end
      checks++; if (busy_owner !== 2'b10) begin failures++; $display("[TB] FAIL accrd_c1_owner got=%b exp=10", busy_owner); end
      tick();
      tick();
      mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
      #1;
      checks++; if (acc_mem_resp !== 1'b1 || acc_data !== 32'hDEADBEEF) begin
         failures++; $display("[TB] FAIL accrd_c3_resp got=%b/%h exp=1/deadbeef", acc_mem_resp, acc_data); end
      checks++; if (cpu_mem_resp !== 1'b0) begin failures++; $display("[TB] FAIL accrd_c3_cpuresp got=%b exp=0", cpu_mem_resp); end
      tick();
      mem_resp = 1'b0; acc_mem_read = 1'b0;
      #1;
      checks++; if (acc_xfer_count !== 32'd1) begin failures++; $display("[TB] FAIL accrd_c4_count got=%0d exp=1", acc_xfer_count); end
      checks++; if (busy_owner !== 2'b00 || mem_read !== 1'b0) begin
         failures++; $display("[TB] FAIL accrd_c4_idle got=%b/%b exp=00/0", busy_owner, mem_read); end
   endtask

   task automatic test_acc_write();
      do_reset();
      acc_mem_write = 1'b1; acc_address = 32'h44; acc_st_data = 32'hCAFEF00D;
      tick(); #1;
      checks++; if ({mem_read, mem_write} !== 2'b01 || mem_address !== 32'h44) begin
         failures++; $display("[TB] FAIL accwr_bus got=%b/%h exp=01/00000044", {mem_read, mem_write}, mem_address); end
      checks++; if (mem_wdata !== 32'hCAFEF00D || mem_wmask !== 4'hF) begin
         failures++; $display("[TB] FAIL accwr_data got=%h/%h exp=cafef00d/f", mem_wdata, mem_wmask); end
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0; acc_mem_write = 1'b0;
      #1;
      checks++; if (acc_xfer_count !== 32'd1) begin failures++; $display("[TB] FAIL accwr_count got=%0d exp=1", acc_xfer_count); end
   endtask

   task automatic test_both_request();
      do_reset();
      cpu_mem_write = 1'b1; cpu_mem_address = 32'h20; cpu_mem_wdata = 32'h12345678; cpu_mem_wmask = 4'b0011;
      acc_mem_read = 1'b1; acc_address = 32'h40;
      tick(); #1;
      checks++; if (busy_owner !== 2'b01) begin failures++; $display("[TB] FAIL both_first_owner got=%b exp=01", busy_owner); end
      checks++; if ({mem_read, mem_write} !== 2'b01 || mem_address !== 32'h20 || mem_wdata !== 32'h12345678) begin
         failures++; $display("[TB] FAIL both_cpu_bus got=%b/%h/%h exp=01/00000020/12345678", {mem_read, mem_write}, mem_address, mem_wdata); end
      checks++; if (mem_wmask !== 4'b0011) begin failures++; $display("[TB] FAIL both_cpu_mask got=%b exp=0011", mem_wmask); end
      mem_resp = 1'b1;
      #1;
      checks++; if ({cpu_mem_resp, acc_mem_resp} !== 2'b10) begin
         failures++; $display("[TB] FAIL both_cpu_resp got=%b exp=10", {cpu_mem_resp, acc_mem_resp}); end
      tick();
      mem_resp = 1'b0; cpu_mem_write = 1'b0;
      #1;
      checks++; if (busy_owner !== 2'b00) begin failures++; $display("[TB] FAIL both_gap got=%b exp=00", busy_owner); end
      tick(); #1;
      checks++; if (busy_owner !== 2'b10 || mem_read !== 1'b1 || mem_address !== 32'h40 || mem_wmask !== 4'hF) begin
         failures++; $display("[TB] FAIL both_acc_grant got=%b/%b/%h/%h exp=10/1/00000040/f", busy_owner, mem_read, mem_address, mem_wmask); end
      mem_resp = 1'b1; mem_rdata = 32'h0BADF00D;
      #1;
      checks++; if ({cpu_mem_resp, acc_mem_resp} !== 2'b01 || acc_data !== 32'h0BADF00D) begin
         failures++; $display("[TB] FAIL both_acc_resp got=%b/%h exp=01/0badf00d", {cpu_mem_resp, acc_mem_resp}, acc_data); end
      tick();
      mem_resp = 1'b0; acc_mem_read = 1'b0;
      #1;
      checks++; if (acc_xfer_count !== 32'd1) begin failures++; $display("[TB] FAIL both_count got=%0d exp=1", acc_xfer_count); end
   endtask

   task automatic test_alternate();
      int n;
      logic [1:0] exp_owner;
      do_reset();
      cpu_mem_read = 1'b1; cpu_mem_address = 32'h300;
      acc_mem_read = 1'b1; acc_address = 32'h500;
      for (int i = 0; i < 8; i++) begin
         exp_owner = (i % 2 == 0) ? 2'b01 : 2'b10;
         n = 0;
         while (busy_owner === 2'b00 && n < 4) begin
            tick(); #1;
            n++;
         end
         checks++; if (busy_owner !== exp_owner) begin
            failures++; $display("[TB] FAIL alt_owner_%0d got=%b exp=%b", i, busy_owner, exp_owner); end
         checks++; if (n !== 1) begin failures++; $display("[TB] FAIL alt_wait_%0d got=%0d exp=1", i, n); end
         mem_resp = 1'b1; mem_rdata = 32'hA000 + i;
         #1;
         checks++; if ({cpu_mem_resp, acc_mem_resp} !== {exp_owner[0], exp_owner[1]}) begin
            failures++; $display("[TB] FAIL alt_resp_%0d got=%b exp=%b", i, {cpu_mem_resp, acc_mem_resp}, {exp_owner[0], exp_owner[1]}); end
         tick();
         mem_resp = 1'b0;
         if (i == 7) begin
            cpu_mem_read = 1'b0;
            acc_mem_read = 1'b0;
         end
         #1;
      end
      tick(); #1;
      checks++; if (acc_xfer_count !== 32'd4 || busy_owner !== 2'b00) begin
         failures++; $display("[TB] FAIL alt_final got=%0d/%b exp=4/00", acc_xfer_count, busy_owner); end
   endtask

   task automatic test_stray_resp();
      do_reset();
      acc_txn(32'h10, 32'h11, 1'b0);
      tick();
      mem_resp = 1'b1; mem_rdata = 32'h5555;
      #1;
      checks++; if ({cpu_mem_resp, acc_mem_resp} !== 2'b00) begin
         failures++; $display("[TB] FAIL stray_resp got=%b exp=00", {cpu_mem_resp, acc_mem_resp}); end
      tick();
      mem_resp = 1'b0;
      #1;
      checks++; if (acc_xfer_count !== 32'd1 || busy_owner !== 2'b00) begin
         failures++; $display("[TB] FAIL stray_count got=%0d/%b exp=1/00", acc_xfer_count, busy_owner); end
   endtask

   task automatic test_clear_collision();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         acc_txn(32'h100 + 4 * i, 32'h0, 1'b0);
         tick();
      end
      checks++; if (acc_xfer_count !== 32'd5) begin failures++; $display("[TB] FAIL clear_pre got=%0d exp=5", acc_xfer_count); end
      acc_txn(32'h200, 32'h0, 1'b1);
      checks++; if (acc_xfer_count !== 32'd0) begin failures++; $display("[TB] FAIL clear_wins got=%0d exp=0", acc_xfer_count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      acc_mem_read = 1'b1; acc_address = 32'h80;
      tick(); #1;
      checks++; if (busy_owner !== 2'b10 || mem_read !== 1'b1) begin
         failures++; $display("[TB] FAIL rmid_busy got=%b/%b exp=10/1", busy_owner, mem_read); end
      reset = 1'b1; acc_mem_read = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      checks++; if (busy_owner !== 2'b00 || mem_read !== 1'b0 || mem_address !== 32'h0) begin
         failures++; $display("[TB] FAIL rmid_idle got=%b/%b/%h exp=00/0/0", busy_owner, mem_read, mem_address); end
      mem_resp = 1'b1;
      #1;
      checks++; if (acc_mem_resp !== 1'b0) begin failures++; $display("[TB] FAIL rmid_resp got=%b exp=0", acc_mem_resp); end
      tick();
      mem_resp = 1'b0;
      #1;
      checks++; if (acc_xfer_count !== 32'd0) begin failures++; $display("[TB] FAIL rmid_count got=%0d exp=0", acc_xfer_count); end
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_acc_read();
      test_acc_write();
      test_both_request();
      test_alternate();
      test_stray_resp();
      test_clear_collision();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
